// File: rtl/cam_wr_en_seq_pkg.sv
// Shared definitions for the camera write-enable pulse sequencer: register map,
// CTRL/STATUS bit positions and the 3-bit sequencer state encoding.
package cam_wr_en_seq_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_ON     = 3'd2;
  localparam logic [2:0] ADDR_OFF    = 3'd3;
  localparam logic [2:0] ADDR_COUNT  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_IRQ_EN = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_TRIG  = 2;
  localparam int CTRL_CONT  = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_REM_LSB   = 8;
  localparam int STAT_STATE_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_ON        = 3'd2,
    ST_OFF       = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/cam_vsync_edge_sync.sv
// Brings the asynchronous camera vsync into the clk domain through a flop chain
// and emits a one-clock pulse on each synchronised rising edge.
module cam_vsync_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cam_wr_en_sequencer.sv
// Avalon-MM programmable pulse-train generator for the camera write-enable bus.
// Define CAM_WR_EN_SEQ_IRQ_EN to add the IRQ_EN register (addr 6) and the done interrupt.
module cam_wr_en_sequencer
  import cam_wr_en_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             cam_vsync,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  seq_state_e       state, state_d;
  logic [CNT_W-1:0] cyc_cnt, cyc_d;
  logic [7:0]       pulses_left, pulses_d;
  logic             start_req, done;

  logic             trig_mode, continuous;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] on_cycles, off_cycles;
  logic [7:0]       count;

  logic wr, ctrl_wr, abort_wr, start_wr, status_clr, busy, vsync_rise;
  logic unused_wd;
  logic [CNT_W-1:0] on_last;

  assign wr         = chipselect & ~write_n;
  assign ctrl_wr    = wr && (address == ADDR_CTRL);
  assign abort_wr   = ctrl_wr & writedata[CTRL_ABORT];
  assign start_wr   = ctrl_wr & writedata[CTRL_START] & ~writedata[CTRL_ABORT];
  assign status_clr = wr && (address == ADDR_STATUS) && writedata[STAT_DONE];
  assign busy       = (state != ST_IDLE);
  assign unused_wd  = ^writedata;
  // ON_CYCLES of zero still yields a single-clock pulse
  assign on_last    = (on_cycles == '0) ? '0 : on_cycles - CNT_W'(1);

  cam_vsync_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
    .clk      (clk),
    .reset    (reset),
    .async_in (cam_vsync),
    .rise     (vsync_rise)
  );

  always_comb begin
    state_d  = state;
    cyc_d    = cyc_cnt + CNT_W'(1);
    pulses_d = pulses_left;
    case (state)
      ST_IDLE: begin
        cyc_d = '0;
        if (start_req) begin
          pulses_d = count;
          if (!continuous && count == '0) state_d = ST_DONE;
          else if (trig_mode)             state_d = ST_WAIT_TRIG;
          else                            state_d = ST_ON;
        end
      end
      ST_WAIT_TRIG: begin
        cyc_d = '0;
        if (vsync_rise) state_d = ST_ON;
      end
      ST_ON: begin
        if (cyc_cnt == on_last) begin
          cyc_d = '0;
          if (!continuous) pulses_d = pulses_left - 8'd1;
          if (continuous || pulses_left > 8'd1)
            state_d = (off_cycles == '0) ? ST_ON : ST_OFF;
          else
            state_d = ST_DONE;
        end
      end
      ST_OFF: begin
        if (cyc_cnt == off_cycles - CNT_W'(1)) begin
          cyc_d   = '0;
          state_d = ST_ON;
        end
      end
      ST_DONE: begin
        cyc_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (abort_wr) begin
      state_d  = ST_IDLE;
      cyc_d    = '0;
      pulses_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cyc_cnt     <= '0;
      pulses_left <= '0;
      start_req   <= 1'b0;
      done        <= 1'b0;
      out_port    <= '0;
    end else begin
      state       <= state_d;
      cyc_cnt     <= cyc_d;
      pulses_left <= pulses_d;
      start_req   <= start_wr & ~busy;
      out_port    <= (state == ST_ON) ? mask : '0;
      if (state == ST_DONE) done <= 1'b1;
      else if (status_clr)  done <= 1'b0;
    end
  end

  // Sequence configuration is frozen while a sequence is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_mode  <= 1'b0;
      continuous <= 1'b0;
      mask       <= '0;
      on_cycles  <= '0;
      off_cycles <= '0;
      count      <= '0;
    end else if (wr && !busy) begin
      case (address)
        ADDR_CTRL: begin
          trig_mode  <= writedata[CTRL_TRIG];
          continuous <= writedata[CTRL_CONT];
        end
        ADDR_MASK:  mask       <= writedata[WIDTH-1:0];
        ADDR_ON:    on_cycles  <= writedata[CNT_W-1:0];
        ADDR_OFF:   off_cycles <= writedata[CNT_W-1:0];
        ADDR_COUNT: count      <= writedata[7:0];
        default: ;
      endcase
    end
  end

`ifdef CAM_WR_EN_SEQ_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (reset)                             irq_en <= 1'b0;
    else if (wr && address == ADDR_IRQ_EN) irq_en <= writedata[0];
  end

  assign irq = done & irq_en;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_TRIG] = trig_mode;
        readdata[CTRL_CONT] = continuous;
      end
      ADDR_MASK:  readdata[WIDTH-1:0] = mask;
      ADDR_ON:    readdata[CNT_W-1:0] = on_cycles;
      ADDR_OFF:   readdata[CNT_W-1:0] = off_cycles;
      ADDR_COUNT: readdata[7:0]       = count;
      ADDR_STATUS: begin
        readdata[STAT_BUSY]               = busy;
        readdata[STAT_DONE]               = done;
        readdata[STAT_REM_LSB +: 8]       = pulses_left;
        readdata[STAT_STATE_LSB +: 3]     = state;
      end
`ifdef CAM_WR_EN_SEQ_IRQ_EN
      ADDR_IRQ_EN: readdata[0] = irq_en;
`endif
      default: ;
    endcase
  end

endmodule
